// File: rtl/cpu6_csrfile.sv
// Machine-mode CSR file: mstatus/misa/mtvec/mscratch/mepc/mcause plus 64-bit
// mcycle and minstret counters, with trap entry and mret handling.
module cpu6_csrfile (
  input  logic        clk,
  input  logic        reset,
  input  logic        csr,
  input  logic        csr_rs1uimm,
  input  logic [1:0]  csr_wsc,
  input  logic [11:0] csr_addr,
  input  logic [4:0]  rs1idx,
  input  logic [31:0] rs1_data,
  input  logic        mret,
  input  logic        trap_req,
  input  logic [31:0] trap_cause,
  input  logic [31:0] trap_pc,
  input  logic        instret,
  output logic [31:0] csr_rdata,
  output logic        csr_illegal,
  output logic [31:0] mtvec_o,
  output logic [31:0] mepc_o,
  output logic        mie_o
);

  logic        mie_q, mie_d;
  logic        mpie_q, mpie_d;
  logic [29:0] mtvec_q, mtvec_d;
  logic [31:0] mscratch_q, mscratch_d;
  logic [29:0] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;
  logic [63:0] mcycle_q, mcycle_d;
  logic [63:0] minstret_q, minstret_d;

  logic        addr_ok;
  logic        write_try;
  logic        wr_en;
  logic [31:0] operand;
  logic [31:0] wval;
  logic [31:0] mstatus_val;
  logic        unused_pc_bits;

  assign unused_pc_bits = ^trap_pc[1:0];

  assign mstatus_val = {19'b0, 2'b11, 3'b000, mpie_q, 3'b000, mie_q, 3'b000};

  always_comb begin
    addr_ok   = 1'b1;
    csr_rdata = 32'h0;
    case (csr_addr)
      12'h300: csr_rdata = mstatus_val;
      12'h301: csr_rdata = 32'h4000_0100;
      12'h305: csr_rdata = {mtvec_q, 2'b00};
      12'h340: csr_rdata = mscratch_q;
      12'h341: csr_rdata = {mepc_q, 2'b00};
      12'h342: csr_rdata = mcause_q;
      12'hB00: csr_rdata = mcycle_q[31:0];
      12'hB80: csr_rdata = mcycle_q[63:32];
      12'hB02: csr_rdata = minstret_q[31:0];
      12'hB82: csr_rdata = minstret_q[63:32];
      default: addr_ok = 1'b0;
    endcase
  end

  // RS/RC with rs1 = x0 is a pure read, so it never counts as a write.
  assign write_try   = (csr_wsc == 2'b01) || (csr_wsc[1] && (rs1idx != 5'd0));
  assign csr_illegal = csr && (!addr_ok || ((csr_addr[11:10] == 2'b11) && write_try));
  assign wr_en       = csr && write_try && !csr_illegal && !trap_req && !mret;
  assign operand     = csr_rs1uimm ? {27'b0, rs1idx} : rs1_data;

  always_comb begin
    case (csr_wsc)
      2'b01:   wval = operand;
      2'b10:   wval = csr_rdata | operand;
      2'b11:   wval = csr_rdata & ~operand;
      default: wval = csr_rdata;
    endcase
  end

  always_comb begin
    mie_d      = mie_q;
    mpie_d     = mpie_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mcycle_d   = mcycle_q + 64'd1;
    minstret_d = minstret_q + {63'b0, instret};
    if (trap_req) begin
      mepc_d   = trap_pc[31:2];
      mcause_d = trap_cause;
      mpie_d   = mie_q;
      mie_d    = 1'b0;
    end else if (mret) begin
      mie_d  = mpie_q;
      mpie_d = 1'b1;
    end else if (wr_en) begin
      // A write to either counter half freezes the whole 64-bit counter this cycle.
      case (csr_addr)
        12'h300: begin
          mie_d  = wval[3];
          mpie_d = wval[7];
        end
        12'h305: mtvec_d    = wval[31:2];
        12'h340: mscratch_d = wval;
        12'h341: mepc_d     = wval[31:2];
        12'h342: mcause_d   = wval;
        12'hB00: mcycle_d   = {mcycle_q[63:32], wval};
        12'hB80: mcycle_d   = {wval, mcycle_q[31:0]};
        12'hB02: minstret_d = {minstret_q[63:32], wval};
        12'hB82: minstret_d = {wval, minstret_q[31:0]};
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mie_q      <= 1'b0;
      mpie_q     <= 1'b0;
      mtvec_q    <= '0;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      mie_q      <= mie_d;
      mpie_q     <= mpie_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
    end
  end

  assign mtvec_o = {mtvec_q, 2'b00};
  assign mepc_o  = {mepc_q, 2'b00};
  assign mie_o   = mie_q;

endmodule

// File: tb/tb_cpu6_csrfile.sv
// Directed bench for cpu6_csrfile: expectations are queued as each cycle's
// stimulus is driven and checked against the outputs on the following falling edge.
module tb_cpu6_csrfile;

  logic        clk = 1'b0;
  logic        reset;
  logic        csr;
  logic        csr_rs1uimm;
  logic [1:0]  csr_wsc;
  logic [11:0] csr_addr;
  logic [4:0]  rs1idx;
  logic [31:0] rs1_data;
  logic        mret;
  logic        trap_req;
  logic [31:0] trap_cause;
  logic [31:0] trap_pc;
  logic        instret;
  logic [31:0] csr_rdata;
  logic        csr_illegal;
  logic [31:0] mtvec_o;
  logic [31:0] mepc_o;
  logic        mie_o;

  int n_cmp = 0;
  int n_bad = 0;

  localparam int K_RDATA = 0, K_ILL = 1, K_MTVEC = 2, K_MEPC = 3, K_MIE = 4;

  int          kind_q[$];
  string       tag_q[$];
  logic [31:0] val_q[$];

  cpu6_csrfile dut (
    .clk(clk), .reset(reset), .csr(csr), .csr_rs1uimm(csr_rs1uimm),
    .csr_wsc(csr_wsc), .csr_addr(csr_addr), .rs1idx(rs1idx), .rs1_data(rs1_data),
    .mret(mret), .trap_req(trap_req), .trap_cause(trap_cause), .trap_pc(trap_pc),
    .instret(instret), .csr_rdata(csr_rdata), .csr_illegal(csr_illegal),
    .mtvec_o(mtvec_o), .mepc_o(mepc_o), .mie_o(mie_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  task automatic expect_out(input int kind, input string tag, input logic [31:0] val);
    kind_q.push_back(kind);
    tag_q.push_back(tag);
    val_q.push_back(val);
  endtask

  // Scoreboard drain: everything queued during this cycle is compared here.
  always @(negedge clk) begin
    while (kind_q.size() > 0) begin
      int k;
      string t;
      logic [31:0] v;
      logic [31:0] act;
      k = kind_q.pop_front();
      t = tag_q.pop_front();
      v = val_q.pop_front();
      case (k)
        K_RDATA: act = csr_rdata;
        K_ILL:   act = {31'b0, csr_illegal};
        K_MTVEC: act = mtvec_o;
        K_MEPC:  act = mepc_o;
        default: act = {31'b0, mie_o};
      endcase
      chk(t, act, v);
    end
  end

  task automatic drive(input logic c, input logic uimm, input logic [1:0] wsc,
                       input logic [11:0] addr, input logic [4:0] idx, input logic [31:0] data);
    csr = c; csr_rs1uimm = uimm; csr_wsc = wsc; csr_addr = addr;
    rs1idx = idx; rs1_data = data;
    mret = 1'b0; trap_req = 1'b0; trap_cause = '0; trap_pc = '0; instret = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 1'b0, 2'b00, 12'h300, 5'd0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state
    drive(1'b0, 1'b0, 2'b00, 12'h300, 5'd0, 32'h0);
    expect_out(K_RDATA, "rst_mstatus", 32'h0000_1800);
    expect_out(K_ILL,   "rst_illegal", 32'h0);
    expect_out(K_MTVEC, "rst_mtvec",   32'h0);
    expect_out(K_MEPC,  "rst_mepc",    32'h0);
    expect_out(K_MIE,   "rst_mie",     32'h0);
    step();

    // csrrw mtvec: old value this cycle, masked new value next cycle
    drive(1'b1, 1'b0, 2'b01, 12'h305, 5'd5, 32'h8000_0107);
    expect_out(K_RDATA, "mtvec_old", 32'h0);
    expect_out(K_ILL,   "mtvec_wr_legal", 32'h0);
    step();
    drive(1'b0, 1'b0, 2'b00, 12'h305, 5'd0, 32'h0);
    expect_out(K_MTVEC, "mtvec_o_new", 32'h8000_0104);
    expect_out(K_RDATA, "mtvec_rd_new", 32'h8000_0104);
    step();

    // csrrsi / csrrc on mstatus.MIE
    drive(1'b1, 1'b1, 2'b10, 12'h300, 5'd8, 32'h0);
    expect_out(K_RDATA, "rsi_mstatus_old", 32'h0000_1800);
    step();
    drive(1'b1, 1'b0, 2'b11, 12'h300, 5'd3, 32'h8);
    expect_out(K_MIE,   "mie_after_rsi", 32'h1);
    expect_out(K_RDATA, "rc_mstatus_old", 32'h0000_1808);
    step();
    // csrrs x0 to mcycle: pure read, legal
    drive(1'b1, 1'b0, 2'b10, 12'hB00, 5'd0, 32'hFFFF_FFFF);
    expect_out(K_MIE, "mie_after_rc", 32'h0);
    expect_out(K_ILL, "rs_x0_mcycle_legal", 32'h0);
    step();
    drive(1'b1, 1'b0, 2'b10, 12'h301, 5'd0, 32'h0);
    expect_out(K_RDATA, "misa", 32'h4000_0100);
    expect_out(K_ILL,   "misa_read_legal", 32'h0);
    step();

    // Trap entry and mret
    drive(1'b1, 1'b1, 2'b10, 12'h300, 5'd8, 32'h0);
    step();
    drive(1'b0, 1'b0, 2'b00, 12'h300, 5'd0, 32'h0);
    trap_req = 1'b1; trap_cause = 32'd2; trap_pc = 32'h0000_1006;
    expect_out(K_MIE,   "mie_before_trap", 32'h1);
    expect_out(K_RDATA, "mstatus_before_trap", 32'h0000_1808);
    step();
    drive(1'b0, 1'b0, 2'b00, 12'h342, 5'd0, 32'h0);
    expect_out(K_MEPC,  "trap_mepc", 32'h0000_1004);
    expect_out(K_RDATA, "trap_mcause", 32'd2);
    expect_out(K_MIE,   "trap_mie", 32'h0);
    step();
    drive(1'b0, 1'b0, 2'b00, 12'h300, 5'd0, 32'h0);
    mret = 1'b1;
    expect_out(K_RDATA, "trap_mstatus", 32'h0000_1880);
    step();
    drive(1'b0, 1'b0, 2'b00, 12'h300, 5'd0, 32'h0);
    expect_out(K_RDATA, "mret_mstatus", 32'h0000_1888);
    expect_out(K_MIE,   "mret_mie", 32'h1);
    step();

    // trap_req + mret + csrrw mscratch together: only the trap lands
    drive(1'b1, 1'b0, 2'b01, 12'h340, 5'd1, 32'hA5A5_A5A5);
    step();
    drive(1'b1, 1'b0, 2'b01, 12'h340, 5'd1, 32'h1234_5678);
    trap_req = 1'b1; mret = 1'b1; trap_cause = 32'h8000_000B; trap_pc = 32'h0000_2000;
    expect_out(K_RDATA, "prio_mscratch_old", 32'hA5A5_A5A5);
    step();
    drive(1'b0, 1'b0, 2'b00, 12'h340, 5'd0, 32'h0);
    expect_out(K_RDATA, "prio_mscratch_kept", 32'hA5A5_A5A5);
    expect_out(K_MEPC,  "prio_mepc", 32'h0000_2000);
    expect_out(K_MIE,   "prio_mie", 32'h0);
    step();
    drive(1'b0, 1'b0, 2'b00, 12'h342, 5'd0, 32'h0);
    expect_out(K_RDATA, "prio_mcause", 32'h8000_000B);
    step();
    drive(1'b0, 1'b0, 2'b00, 12'h300, 5'd0, 32'h0);
    expect_out(K_RDATA, "prio_mstatus", 32'h0000_1880);
    step();

    // mcycle carry into mcycleh
    drive(1'b1, 1'b0, 2'b01, 12'hB80, 5'd1, 32'h0);
    step();
    drive(1'b1, 1'b0, 2'b01, 12'hB00, 5'd1, 32'hFFFF_FFFF);
    step();
    drive(1'b0, 1'b0, 2'b00, 12'hB00, 5'd0, 32'h0);
    expect_out(K_RDATA, "mcycle_written", 32'hFFFF_FFFF);
    step();
    drive(1'b0, 1'b0, 2'b00, 12'hB80, 5'd0, 32'h0);
    expect_out(K_RDATA, "mcycleh_carry", 32'h1);
    step();
    drive(1'b0, 1'b0, 2'b00, 12'hB00, 5'd0, 32'h0);
    expect_out(K_RDATA, "mcycle_after_carry", 32'h1);
    step();

    // Illegal accesses change nothing
    drive(1'b1, 1'b0, 2'b01, 12'hC00, 5'd1, 32'h5);
    expect_out(K_ILL, "ill_c00", 32'h1);
    step();
    drive(1'b1, 1'b0, 2'b01, 12'h7FF, 5'd1, 32'h5);
    expect_out(K_ILL, "ill_7ff", 32'h1);
    step();
    drive(1'b1, 1'b0, 2'b01, 12'h340, 5'd1, 32'h0);
    expect_out(K_ILL, "ill_mscratch_w_legal", 32'h0);
    expect_out(K_RDATA, "ill_mscratch_kept", 32'hA5A5_A5A5);
    step();
    drive(1'b1, 1'b0, 2'b01, 12'hB00, 5'd1, 32'h0);
    expect_out(K_ILL, "ill_mcycle_w_legal", 32'h0);
    step();

    // Reset mid-sequence with minstret=5 and instret=1
    drive(1'b1, 1'b0, 2'b01, 12'hB82, 5'd1, 32'h0);
    step();
    drive(1'b1, 1'b0, 2'b01, 12'hB02, 5'd1, 32'h5);
    step();
    drive(1'b1, 1'b1, 2'b10, 12'h300, 5'd8, 32'h0);
    expect_out(K_RDATA, "pre_rst_mstatus", 32'h0000_1880);
    step();
    drive(1'b0, 1'b0, 2'b00, 12'hB02, 5'd0, 32'h0);
    expect_out(K_RDATA, "pre_rst_minstret", 32'd5);
    expect_out(K_MIE,   "pre_rst_mie", 32'h1);
    step();
    drive(1'b1, 1'b0, 2'b01, 12'hB02, 5'd1, 32'hFFFF_FFFF);
    instret = 1'b1;
    reset = 1'b1;
    step();
    reset = 1'b0;
    drive(1'b0, 1'b0, 2'b00, 12'hB02, 5'd0, 32'h0);
    expect_out(K_RDATA, "post_rst_minstret", 32'h0);
    expect_out(K_MIE,   "post_rst_mie", 32'h0);
    expect_out(K_MTVEC, "post_rst_mtvec", 32'h0);
    step();
    drive(1'b0, 1'b0, 2'b00, 12'hB00, 5'd0, 32'h0);
    instret = 1'b1;
    expect_out(K_RDATA, "post_rst_mcycle", 32'h1);
    step();
    drive(1'b0, 1'b0, 2'b00, 12'hB02, 5'd0, 32'h0);
    expect_out(K_RDATA, "minstret_inc", 32'h1);
    step();

    @(negedge clk);
    #1;
    chk("scoreboard_drained", kind_q.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cpu6_csrfile.md
CPU6_CSRFILE -- requirements
Module: cpu6_csrfile

Interface
REQ-001 SHALL: clk  input  1  single clock; all state updates on the rising edge.
REQ-002 SHALL: reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-003 SHALL: csr  input  1  CSR instruction valid this cycle (decoder csr enable).
REQ-004 SHALL: csr_rs1uimm  input  1  operand select: 0 = rs1_data, 1 = zero-extended rs1idx (uimm).
REQ-005 SHALL: csr_wsc  input  2  operation: 01 = write (RW), 10 = set (RS), 11 = clear (RC), 00 = no operation.
REQ-006 SHALL: csr_addr  input  12  CSR address (instr[31:20]).
REQ-007 SHALL: rs1idx  input  5  rs1 field, used both as uimm and for the x0/zero test.
REQ-008 SHALL: rs1_data  input  32  rs1 register value.
REQ-009 SHALL: mret  input  1  mret instruction valid this cycle.
REQ-010 SHALL: trap_req, trap_cause[31:0], trap_pc[31:0]  input  1/32/32  trap entry request, mcause value, and faulting PC.
REQ-011 SHALL: instret  input  1  one instruction retired this cycle.
REQ-012 SHALL: csr_rdata  output  32  old CSR value, combinational from csr_addr.
REQ-013 SHALL: csr_illegal  output  1  combinational; high when csr=1 and the access is illegal.
REQ-014 SHALL: mtvec_o, mepc_o  output  32  current mtvec and mepc, used for redirect on trap or mret.
REQ-015 SHALL: mie_o  output  1  current mstatus.MIE.

Function
REQ-016 SHALL: implement these CSRs only:
- misa 0x301: read-only, value 0x40000100.
- mstatus 0x300: MIE bit 3, MPIE bit 7, MPP bits 12:11 read as 11; all other bits read 0.
- mtvec 0x305: bits 1:0 read 0 (direct mode).
- mscratch 0x340: full 32 bits.
- mepc 0x341: bits 1:0 read 0.
- mcause 0x342: full 32 bits.
- mcycle/mcycleh 0xB00/0xB80.
- minstret/minstreth 0xB02/0xB82.
REQ-017 SHALL: assert csr_illegal when csr=1 and either the address is unimplemented, or csr_addr[11:10]=11 (read-only space) while a write is attempted; an illegal access SHALL change no state.
REQ-018 SHALL: compute the operand as csr_rs1uimm ? {27'b0, rs1idx} : rs1_data.
REQ-019 SHALL: compute the new value as operand (RW), old|operand (RS), or old&~operand (RC).
REQ-020 SHALL: treat a write as attempted for RW always, and for RS/RC only when rs1idx != 0; an RS/RC with rs1idx = 0 is a pure read, including to read-only CSRs.
REQ-021 SHALL: commit CSR writes at the next rising edge; csr_rdata in the same cycle returns the pre-write value.
REQ-022 SHALL: on trap_req, at the next edge:
- mepc <= {trap_pc[31:2], 2'b00}
- mcause <= trap_cause
- MPIE <= MIE
- MIE <= 0
REQ-023 SHALL: on mret (no trap_req), at the next edge: MIE <= MPIE and MPIE <= 1.
REQ-024 SHALL: apply priority in the same cycle as trap_req > mret > CSR write; a lower-priority event is dropped entirely, with no partial update.
REQ-025 SHALL: increment the 64-bit mcycle every cycle not in reset, and wrap from 0xFFFFFFFF_FFFFFFFF to 0.
REQ-026 SHALL: increment the 64-bit minstret when instret=1, and wrap from 0xFFFFFFFF_FFFFFFFF to 0.
REQ-027 SHALL: let a committed CSR write to a counter half replace that half, with the increment suppressed for the whole 64-bit counter that cycle.
REQ-028 SHALL: propagate a carry from the low half into the high half in the same cycle (0x00000000_FFFFFFFF -> 0x00000001_00000000).

Reset
REQ-029 SHALL: while reset=1, set MIE=0, MPIE=0, mtvec=0, mscratch=0, mepc=0, mcause=0, mcycle=0, minstret=0; all other inputs are ignored.
REQ-030 SHALL: drive outputs after reset as csr_rdata per csr_addr (e.g. mstatus reads 0x00001800), csr_illegal=0 when csr=0, mtvec_o=0, mepc_o=0, mie_o=0.
REQ-031 SHALL: discard any trap, mret or CSR write coincident with a reset edge; reset wins.

Verification
REQ-032 SHALL: csrrw 0x305 with rs1_data=0x80000107 -> csr_rdata=0 that cycle; mtvec_o=0x80000104 next cycle.
REQ-033 SHALL: csrrsi 0x300 with uimm=8, then csrrc 0x300 with rs1_data=0x8 -> mie_o=1 after the first edge, 0 after the second; csrrs with rs1idx=0 on 0xB00 -> no write, csr_illegal=0.
REQ-034 SHALL: MIE=1, trap_req with trap_cause=2, trap_pc=0x1006 -> mepc_o=0x1004, mcause=2, MIE=0, MPIE=1; then mret -> MIE=1, MPIE=1.
REQ-035 SHALL: trap_req, mret and csrrw 0x340 in the same cycle -> only the trap effects apply; mscratch unchanged.
REQ-036 SHALL: write mcycle=0xFFFFFFFF with mcycleh=0 -> the following cycle reads mcycleh=1, mcycle=0x00000000 (plus elapsed cycles); a write to 0xC00 or 0x7FF -> csr_illegal=1, no state change.
REQ-037 SHALL: assert reset mid-sequence with minstret=5 and instret=1 -> minstret=0 and mie_o=0 on the next cycle.
